// File: rtl/wr_circ_buf_ctrl_if.sv
// Handshake, header and datapath strobe/status bundle between the circular-buffer
// write controller (master) and its source, memory and datapath neighbours (slave).
interface wr_circ_buf_ctrl_if #(
  parameter int MSG_DATA_SIZE_WIDTH = 16
);
  logic                           src_wr_buf_req_val;
  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_buf_req_size;
  logic                           wr_buf_src_req_rdy;
  logic                           src_wr_buf_req_data_val;
  logic                           wr_buf_src_req_data_rdy;
  logic                           wr_buf_wr_mem_req_val;
  logic                           wr_mem_wr_buf_req_rdy;
  logic                           wr_buf_wr_mem_req_data_val;
  logic                           wr_mem_wr_buf_req_data_rdy;
  logic                           wr_mem_wr_buf_resp_val;
  logic                           wr_buf_wr_mem_resp_rdy;
  logic                           wr_buf_src_req_done_val;
  logic                           src_wr_buf_req_done_rdy;
  logic                           store_req_metadata;
  logic                           update_wr_req_metadata;
  logic                           init_curr_req_rem_bytes;
  logic                           update_curr_req_rem_bytes;
  logic                           store_save_reg;
  logic                           store_save_reg_shift;
  logic                           clear_save_reg_shift;
  logic                           split_req;
  logic                           save_reg_has_unused;
  logic                           datap_ctrl_need_input;
  logic                           wr_buf_wr_mem_req_data_last;

  modport master (
    input  src_wr_buf_req_val, src_wr_buf_req_size, src_wr_buf_req_data_val,
           wr_mem_wr_buf_req_rdy, wr_mem_wr_buf_req_data_rdy, wr_mem_wr_buf_resp_val,
           src_wr_buf_req_done_rdy, split_req, save_reg_has_unused,
           datap_ctrl_need_input, wr_buf_wr_mem_req_data_last,
    output wr_buf_src_req_rdy, wr_buf_src_req_data_rdy, wr_buf_wr_mem_req_val,
           wr_buf_wr_mem_req_data_val, wr_buf_wr_mem_resp_rdy, wr_buf_src_req_done_val,
           store_req_metadata, update_wr_req_metadata, init_curr_req_rem_bytes,
           update_curr_req_rem_bytes, store_save_reg, store_save_reg_shift,
           clear_save_reg_shift
  );

  modport slave (
    output src_wr_buf_req_val, src_wr_buf_req_size, src_wr_buf_req_data_val,
           wr_mem_wr_buf_req_rdy, wr_mem_wr_buf_req_data_rdy, wr_mem_wr_buf_resp_val,
           src_wr_buf_req_done_rdy, split_req, save_reg_has_unused,
           datap_ctrl_need_input, wr_buf_wr_mem_req_data_last,
    input  wr_buf_src_req_rdy, wr_buf_src_req_data_rdy, wr_buf_wr_mem_req_val,
           wr_buf_wr_mem_req_data_val, wr_buf_wr_mem_resp_rdy, wr_buf_src_req_done_val,
           store_req_metadata, update_wr_req_metadata, init_curr_req_rem_bytes,
           update_curr_req_rem_bytes, store_save_reg, store_save_reg_shift,
           clear_save_reg_shift
  );
endinterface

// File: rtl/wr_circ_buf_ctrl.sv
// Control FSM sequencing one source request into a circular buffer: one memory
// write, or two when the write wraps past the buffer end.
module wr_circ_buf_ctrl #(
  parameter int BUF_PTR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  wr_circ_buf_ctrl_if.master  bus
);

  if (BUF_PTR_W < 1) begin : g_ptr_w_check
    $error("wr_circ_buf_ctrl: BUF_PTR_W must be at least 1");
  end

  // IDLE: take header | MEM_REQ: issue write | DATA: stream beats | WAIT_RESP: await write ack | DONE: report completion
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_REQ   = 3'd1,
    DATA      = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   final_chunk_q, final_chunk_d;
  logic   need_in;
  logic   beat_fire;

  assign need_in = !bus.save_reg_has_unused | !bus.wr_buf_wr_mem_req_data_last |
                   bus.datap_ctrl_need_input;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      final_chunk_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      final_chunk_q <= final_chunk_d;
    end
  end

  always_comb begin
    state_d                        = state_q;
    final_chunk_d                  = final_chunk_q;
    beat_fire                      = 1'b0;
    bus.wr_buf_src_req_rdy         = 1'b0;
    bus.wr_buf_src_req_data_rdy    = 1'b0;
    bus.wr_buf_wr_mem_req_val      = 1'b0;
    bus.wr_buf_wr_mem_req_data_val = 1'b0;
    bus.wr_buf_wr_mem_resp_rdy     = 1'b0;
    bus.wr_buf_src_req_done_val    = 1'b0;
    bus.store_req_metadata         = 1'b0;
    bus.update_wr_req_metadata     = 1'b0;
    bus.init_curr_req_rem_bytes    = 1'b0;
    bus.update_curr_req_rem_bytes  = 1'b0;
    bus.store_save_reg             = 1'b0;
    bus.store_save_reg_shift       = 1'b0;
    bus.clear_save_reg_shift       = 1'b0;

    case (state_q)
      IDLE: begin
        bus.wr_buf_src_req_rdy = 1'b1;
        if (bus.src_wr_buf_req_val) begin
          bus.store_req_metadata   = 1'b1;
          bus.clear_save_reg_shift = 1'b1;
          state_d = (bus.src_wr_buf_req_size == '0) ? DONE : MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.wr_buf_wr_mem_req_val = 1'b1;
        if (bus.wr_mem_wr_buf_req_rdy) begin
          bus.init_curr_req_rem_bytes = 1'b1;
          bus.update_wr_req_metadata  = 1'b1;
          final_chunk_d = !bus.split_req;
          state_d       = DATA;
        end
      end
      DATA: begin
        // When the save register alone can finish the chunk, the beat goes out without a source line.
        bus.wr_buf_wr_mem_req_data_val = need_in ? bus.src_wr_buf_req_data_val : 1'b1;
        bus.wr_buf_src_req_data_rdy    = need_in & bus.src_wr_buf_req_data_val &
                                         bus.wr_mem_wr_buf_req_data_rdy;
        beat_fire = bus.wr_buf_wr_mem_req_data_val & bus.wr_mem_wr_buf_req_data_rdy;
        if (beat_fire) begin
          bus.update_curr_req_rem_bytes = 1'b1;
          bus.store_save_reg            = need_in;
          if (bus.wr_buf_wr_mem_req_data_last) begin
            bus.store_save_reg_shift = !final_chunk_q;
            bus.clear_save_reg_shift = final_chunk_q;
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        bus.wr_buf_wr_mem_resp_rdy = 1'b1;
        if (bus.wr_mem_wr_buf_resp_val) begin
          state_d = final_chunk_q ? DONE : MEM_REQ;
        end
      end
      DONE: begin
        bus.wr_buf_src_req_done_val = 1'b1;
        if (bus.src_wr_buf_req_done_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/wr_circ_buf_ctrl.md
# wr_circ_buf_ctrl

Control FSM that sequences `wr_circ_buf_datapath` to write one source request into a per-flow circular buffer in memory. It accepts a request header and its data lines, and issues one memory write request, or two when the write wraps past the buffer end. It streams realigned data lines to memory, waits for each write response, and signals completion back to the source. It produces only the datapath strobes and handshakes; the datapath holds all addresses, sizes and data.

## Interface
- `BUF_PTR_W`, default 12: circular-buffer pointer width; must match the datapath instance.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `src_wr_buf_req_val` input 1: request header valid.
- `src_wr_buf_req_size` input `MSG_DATA_SIZE_WIDTH`: header byte count, used for the zero-size check.
- `wr_buf_src_req_rdy` output 1: header accepted.
- `src_wr_buf_req_data_val` input 1: source data line valid.
- `wr_buf_src_req_data_rdy` output 1: source data line consumed.
- `wr_buf_wr_mem_req_val` output 1: memory write request valid; address and size come from the datapath `mem_req_struct`.
- `wr_mem_wr_buf_req_rdy` input 1: memory write request accepted.
- `wr_buf_wr_mem_req_data_val` output 1: memory write data line valid.
- `wr_mem_wr_buf_req_data_rdy` input 1: memory write data line accepted.
- `wr_mem_wr_buf_resp_val` input 1: memory write complete.
- `wr_buf_wr_mem_resp_rdy` output 1: write response accepted.
- `wr_buf_src_req_done_val` output 1: whole request written.
- `src_wr_buf_req_done_rdy` input 1: done acknowledged.
- `store_req_metadata`, `update_wr_req_metadata`, `init_curr_req_rem_bytes`, `update_curr_req_rem_bytes`, `store_save_reg`, `store_save_reg_shift`, `clear_save_reg_shift`: outputs, 1 bit each; datapath strobes.
- `split_req`, `save_reg_has_unused`, `datap_ctrl_need_input`, `wr_buf_wr_mem_req_data_last`: inputs, 1 bit each; datapath status.

## Operation
**State machine.** States are IDLE, MEM_REQ, DATA, WAIT_RESP and DONE. One 1-bit register, `final_chunk_reg`, is kept alongside the state.

**IDLE**
- `wr_buf_src_req_rdy`=1.
- On header fire: pulse `store_req_metadata` and `clear_save_reg_shift`.
- If size==0, go to DONE with no memory traffic; otherwise go to MEM_REQ.

**MEM_REQ**
- `wr_buf_wr_mem_req_val`=1.
- On fire, in the same cycle: pulse `init_curr_req_rem_bytes` and `update_wr_req_metadata`; load `final_chunk_reg` = !`split_req`; go to DATA.

**DATA**
- Define `need_in` = !`save_reg_has_unused` | !`wr_buf_wr_mem_req_data_last` | `datap_ctrl_need_input`.
- `wr_buf_wr_mem_req_data_val` = `need_in` ? `src_wr_buf_req_data_val` : 1.
- `wr_buf_src_req_data_rdy` = `need_in` & `src_wr_buf_req_data_val` & `wr_mem_wr_buf_req_data_rdy`. A source line is consumed only on a memory beat fire.
- On every beat fire: pulse `update_curr_req_rem_bytes`; also pulse `store_save_reg` if `need_in`.
- On a beat fire with `data_last`=1:
  - If `final_chunk_reg`=0, pulse `store_save_reg_shift`; the carried bytes feed chunk 2.
  - If `final_chunk_reg`=1, pulse `clear_save_reg_shift`.
  - Go to WAIT_RESP.

**WAIT_RESP**
- `wr_buf_wr_mem_resp_rdy`=1.
- On response: go to DONE if `final_chunk_reg`, otherwise to MEM_REQ.

**DONE**
- `wr_buf_src_req_done_val`=1.
- On `src_wr_buf_req_done_rdy`: go to IDLE.

**Invariants**
- At most one memory request is outstanding.
- A request splits at most once, because its size never exceeds the buffer. The first chunk therefore always starts with shift 0.
- When chunk 1 ends on a full line, the datapath shift register truncates to 0, so no carry is produced. This is required behaviour.
- Strobes are pulses in the fire cycle only; all strobes are 0 in every other cycle.

## Timing
**Reset**
- `rst_n` low forces IDLE and `final_chunk_reg`=0 immediately, including mid-transfer. Any in-flight memory transaction is abandoned.
- During reset all valid outputs and all strobes are 0; `wr_buf_src_req_rdy`=1, since it is decoded from IDLE.
- The source must not present a header while `rst_n` is low.

**Latency**
- Header fire to `wr_buf_wr_mem_req_val`: 1 cycle.
- Memory request fire to the first data valid: 1 cycle.
- One data beat per cycle at full throughput.
- Response to the next memory request, or to done: 1 cycle.
- Done fire to `wr_buf_src_req_rdy`: 1 cycle.

**Handshakes and outputs**
- Every handshake is val&rdy in the same cycle.
- Once a valid is raised it stays high until its fire.
- All outputs are combinational from state, registers and inputs; there are no registered outputs.

## Test plan
- Non-split request: ptr=0, size=100. Expect one memory request of size 100, 2 beats (padbytes 0 then 28), 2 source lines consumed, 1 response, then done.
- Split with extra input: ptr=4090, size=70.
  - Chunk 1: size 6 at addr 4090, 1 beat with padbytes 58; `store_save_reg_shift` pulses.
  - Chunk 2: size 64 at addr 0, 1 beat that consumes the second source line.
  - Totals: 2 lines consumed, 2 responses, then done.
- Split with no extra input: ptr=4090, size=60. Chunk 2 is size 54 and its beat fires with `wr_buf_src_req_data_rdy`=0. Exactly 1 source line is consumed in total.
- Zero size: header with size=0. Expect done 1 cycle after the header fire; no `wr_buf_wr_mem_req_val`.
- Backpressure: toggle `wr_mem_wr_buf_req_data_rdy` and `src_wr_buf_req_data_val` randomly on the 100-byte case. Valids must never drop before fire, and no line may be lost or duplicated.
- Mid-transfer reset: assert `rst_n`=0 during DATA. Expect IDLE in the same cycle, all valids 0, and a following normal request to complete correctly.
